vga_fetch_fifo: RTL and testbench

- Upstream feeder for the 640x480 bitplane video output stage.
- Reads the framebuffer from the CPU-side memory bus as 32-bit words, one word per 8 pixels, into a small show-ahead FIFO.
- Presents the FIFO head as red_byte/green_byte/blue_byte/bright_byte; advances by one word on each rd pulse from the video stage.
- Restarts at base_addr on every vertical sync.

---
 rtl/vga_fetch_fifo_pkg.sv | 19 +
 rtl/vga_fetch_fifo_fifo.sv | 69 ++++++
 rtl/vga_fetch_fifo.sv | 132 +++++++++++++
 tb/tb_vga_fetch_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fetch_fifo_pkg.sv
// Shared state encoding and constants for the framebuffer fetch unit.
// Byte lanes map one 32-bit word onto the four bitplanes.
package vga_fetch_fifo_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int FRAME_WORDS_DEF = 640 * 480 / 8;

  localparam int RED_LSB    = 0;
  localparam int GREEN_LSB  = 8;
  localparam int BLUE_LSB   = 16;
  localparam int BRIGHT_LSB = 24;

endpackage

// File: rtl/vga_fetch_fifo_fifo.sv
// Show-ahead FIFO: head_o is a registered copy of the oldest entry.
// Flush clears pointers, count and head in one cycle.
module vga_fifo_sync #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic [WIDTH-1:0]      head_o
);

  localparam logic [DEPTH_LOG2:0] DEPTH =
    {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE =
    (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PONE =
    DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [0:(2**DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wp_q, rp_q, rp_nxt;
  logic [DEPTH_LOG2:0]   count_q;
  logic [WIDTH-1:0]      head_q;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_push = push_i & (count_q != DEPTH);
  assign do_pop  = pop_i & ~empty_o;
  assign rp_nxt  = rp_q + PONE;
  assign count_o = count_q;
  assign head_o  = head_q;

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (flush_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + PONE;
      if (do_pop)  rp_q <= rp_nxt;
      count_q <= count_q
               + {{DEPTH_LOG2{1'b0}}, do_push}
               - {{DEPTH_LOG2{1'b0}}, do_pop};
      // last entry popped alone: head keeps its old value
      if (do_pop) begin
        if (count_q > ONE)  head_q <= mem_q[rp_nxt];
        else if (do_push)   head_q <= din_i;
      end else if (empty_o && do_push) begin
        head_q <= din_i;
      end
    end
  end

endmodule

// File: rtl/vga_fetch_fifo.sv
// Framebuffer fetcher: one bus word per 8 pixels into a show-ahead FIFO,
// restarting at base_addr on every vsync assertion.
module vga_fetch_fifo
  import vga_fetch_fifo_pkg::*;
#(
  parameter int addr_width      = 30,
  parameter int fifo_depth_log2 = 4,
  parameter int frame_words     = FRAME_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [addr_width-1:0] base_addr,
  input  logic                  vga_vsync,
  output logic                  addr_strobe,
  output logic [addr_width-1:0] addr,
  input  logic                  data_ready,
  input  logic [31:0]           data_in,
  input  logic                  rd,
  output logic [7:0]            red_byte,
  output logic [7:0]            green_byte,
  output logic [7:0]            blue_byte,
  output logic [7:0]            bright_byte,
  output logic                  underflow
);

  localparam int CW = $clog2(frame_words + 1);
  localparam logic [CW-1:0] FW = CW'(frame_words);
  localparam logic [fifo_depth_log2:0] DEPTH =
    {1'b1, {fifo_depth_log2{1'b0}}};

  logic [2:0]            vs_q;
  logic                  frame_start;
  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  stb_q, stb_d;
  logic [CW-1:0]         wcnt_q, wcnt_d, wcnt_inc;
  logic                  uf_q;
  logic                  restart, push;
  logic [fifo_depth_log2:0] fifo_cnt;
  logic                  fifo_empty;
  logic [31:0]           head;

  // vs_q[1:0] synchronize; vs_q[2] is the edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vs_q <= 3'b111;
    else          vs_q <= {vs_q[1:0], vga_vsync};
  end

  assign frame_start = vs_q[2] & ~vs_q[1];
  assign wcnt_inc    = wcnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stb_d   = stb_q;
    wcnt_d  = wcnt_q;
    restart = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (frame_start) restart = 1'b1;
      end
      S_FETCH: begin
        if (frame_start && stb_q && !data_ready) begin
          state_d = S_DRAIN;
        end else if (frame_start) begin
          restart = 1'b1;
        end else if (stb_q) begin
          if (data_ready) begin
            push   = 1'b1;
            stb_d  = 1'b0;
            addr_d = addr_q + addr_width'(1);
            wcnt_d = wcnt_inc;
            if (wcnt_inc == FW) state_d = S_DONE;
          end
        end else if (fifo_cnt < DEPTH && wcnt_q < FW) begin
          stb_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (data_ready) restart = 1'b1;
      end
    endcase
    if (restart) begin
      state_d = S_FETCH;
      addr_d  = base_addr;
      stb_d   = 1'b0;
      wcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      stb_q   <= 1'b0;
      wcnt_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stb_q   <= stb_d;
      wcnt_q  <= wcnt_d;
      if (restart)                uf_q <= 1'b0;
      else if (rd && fifo_empty)  uf_q <= 1'b1;
    end
  end

  vga_fifo_sync #(
    .DEPTH_LOG2 (fifo_depth_log2),
    .WIDTH      (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .din_i   (data_in),
    .pop_i   (rd),
    .flush_i (restart),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign addr_strobe = stb_q;
  assign addr        = addr_q;
  assign underflow   = uf_q;
  assign red_byte    = head[RED_LSB +: 8];
  assign green_byte  = head[GREEN_LSB +: 8];
  assign blue_byte   = head[BLUE_LSB +: 8];
  assign bright_byte = head[BRIGHT_LSB +: 8];

endmodule

// File: tb/tb_vga_fetch_fifo.sv
// Scoreboard bench for vga_fetch_fifo: expected addresses and heads are
// queued by the stimulus and checked by a separate monitor.
module tb_vga_fetch_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [29:0] base_addr;
  logic        vga_vsync, addr_strobe, data_ready, rd, underflow;
  logic [29:0] addr;
  logic [31:0] data_in;
  logic [7:0]  red_byte, green_byte, blue_byte, bright_byte;

  logic        d4_vsync, d4_strobe, d4_ready, d4_rd, d4_uf;
  logic [29:0] d4_addr;
  logic [31:0] d4_data;
  logic [7:0]  d4_r, d4_g, d4_b, d4_br;

  vga_fetch_fifo dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .vga_vsync(vga_vsync), .addr_strobe(addr_strobe), .addr(addr),
    .data_ready(data_ready), .data_in(data_in), .rd(rd),
    .red_byte(red_byte), .green_byte(green_byte),
    .blue_byte(blue_byte), .bright_byte(bright_byte),
    .underflow(underflow)
  );

  vga_fetch_fifo #(.frame_words(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .vga_vsync(d4_vsync), .addr_strobe(d4_strobe), .addr(d4_addr),
    .data_ready(d4_ready), .data_in(d4_data), .rd(d4_rd),
    .red_byte(d4_r), .green_byte(d4_g),
    .blue_byte(d4_b), .bright_byte(d4_br),
    .underflow(d4_uf)
  );

  int checks = 0;
  int fails = 0;
  int ack_cnt = 0;
  int d4_acks = 0;
  int ack_dly = 0;
  bit mem_en = 1'b0;
  logic [29:0] exp_addr[$];
  logic [29:0] d4_exp[$];
  logic [31:0] exp_head[$];

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return 32'h80402010 ^ {4{a[7:0]}};
  endfunction

  function automatic logic [31:0] head_val();
    return {bright_byte, blue_byte, green_byte, red_byte};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // memory model: acks the pending request after ack_dly cycles
  initial begin
    data_ready = 1'b0;
    data_in = '0;
    forever begin
      @(posedge clk); #1;
      data_ready = 1'b0;
      if (mem_en && addr_strobe && reset_n) begin
        for (int i = 0; i < ack_dly; i++) begin
          @(posedge clk); #1;
        end
        if (addr_strobe) begin
          data_ready = 1'b1;
          data_in = word_of(addr);
        end
      end
    end
  end

  initial begin
    d4_ready = 1'b0;
    d4_data = 32'hA5A50000;
    forever begin
      @(posedge clk); #1;
      d4_ready = d4_strobe && !d4_ready;
    end
  end

  // monitor
  initial begin
    logic rd_prev;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rd_prev) begin
        if (exp_head.size() > 0)
          chk("head", head_val(), exp_head.pop_front());
        else
          chk("head_queue", exp_head.size(), 1);
      end
      rd_prev = rd;
      if (addr_strobe && data_ready) begin
        ack_cnt++;
        if (exp_addr.size() > 0)
          chk("ack_addr", addr, exp_addr.pop_front());
        else
          chk("ack_queue", exp_addr.size(), 1);
      end
      if (d4_strobe && d4_ready) begin
        d4_acks++;
        if (d4_exp.size() > 0)
          chk("d4_addr", d4_addr, d4_exp.pop_front());
        else
          chk("d4_queue", d4_exp.size(), 1);
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; vga_vsync = 1'b1; base_addr = 30'h1000;
    rd = 1'b0; d4_vsync = 1'b1; d4_rd = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_strobe", addr_strobe, 0);
    chk("rst_addr", addr, 0);
    chk("rst_head", head_val(), 0);
    chk("rst_uf", underflow, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) exp_addr.push_back(30'h1000 + 30'(i));
    mem_en = 1'b1; vga_vsync = 1'b0;
    n = 0;
    while (!addr_strobe && n < 8) begin @(negedge clk); n++; end
    chk("fs_latency", n, 4);
    chk("first_addr", addr, 32'h1000);
    vga_vsync = 1'b1;
    @(negedge clk); #2;
    chk("first_head", head_val(), 32'h80402010);
    chk("first_bright", bright_byte, 8'h80);
    chk("first_red", red_byte, 8'h10);

    n = 0;
    while (ack_cnt < 16 && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    #2;
    chk("fill_acks", ack_cnt, 16);
    chk("full_strobe", addr_strobe, 0);
    chk("full_addr", addr, 32'h1010);

    exp_addr.push_back(30'h1010);
    @(negedge clk); rd = 1'b1; exp_head.push_back(word_of(30'h1001));
    @(negedge clk); rd = 1'b0;
    n = 0;
    while (ack_cnt < 17 && n < 20) begin @(negedge clk); n++; end
    chk("refill_acks", ack_cnt, 17);
    mem_en = 1'b0;

    for (int i = 1; i <= 17; i++) begin
      @(negedge clk); rd = 1'b1;
      exp_head.push_back(word_of(30'h1001 + 30'((i < 16) ? i : 15)));
    end
    @(negedge clk); rd = 1'b0;
    #2;
    chk("uf_set", underflow, 1);

    @(negedge clk);
    exp_addr.push_back(30'h1011);
    ack_dly = 5; mem_en = 1'b1; vga_vsync = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("drain_uf_held", underflow, 1);
    chk("drain_strobe", addr_strobe, 1);
    chk("drain_addr", addr, 32'h1011);
    vga_vsync = 1'b1;
    @(negedge clk); vga_vsync = 1'b0;
    n = 0;
    while (ack_cnt < 18 && n < 30) begin @(negedge clk); n++; end
    #2;
    chk("drain_acks", ack_cnt, 18);
    chk("drain_strobe_off", addr_strobe, 0);
    chk("drain_head_flushed", head_val(), 0);
    chk("drain_uf_cleared", underflow, 0);
    chk("drain_restart_addr", addr, 32'h1000);

    ack_dly = 0; vga_vsync = 1'b1;
    for (int i = 0; i < 3; i++) exp_addr.push_back(30'h1000 + 30'(i));
    n = 0;
    while (ack_cnt < 21 && n < 30) begin @(negedge clk); n++; end
    mem_en = 1'b0;
    chk("three_acks", ack_cnt, 21);
    repeat (3) @(negedge clk);
    exp_addr.push_back(30'h1003);
    mem_en = 1'b1;
    @(negedge clk); rd = 1'b1; exp_head.push_back(word_of(30'h1001));
    @(negedge clk); rd = 1'b0; mem_en = 1'b0;
    #2;
    chk("simul_ack", ack_cnt, 22);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) chk("uf_before_empty_rd", underflow, 0);
      rd = 1'b1;
      exp_head.push_back(word_of(30'h1001 + 30'((i < 2) ? i : 2)));
    end
    @(negedge clk); rd = 1'b0;
    #2;
    chk("uf_after_three", underflow, 1);

    @(negedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_strobe", addr_strobe, 0);
    chk("async_addr", addr, 0);
    chk("async_head", head_val(), 0);
    chk("async_uf", underflow, 0);
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("head_queue_empty", exp_head.size(), 0);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) d4_exp.push_back(30'h1000 + 30'(i));
    d4_vsync = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    chk("d4_frame_acks", d4_acks, 4);
    chk("d4_done_strobe", d4_strobe, 0);
    chk("d4_done_addr", d4_addr, 32'h1004);
    n = 0;
    repeat (10) begin @(negedge clk); if (d4_strobe) n++; end
    chk("d4_idle_cycles", n, 0);
    d4_vsync = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) d4_exp.push_back(30'h1000 + 30'(i));
    d4_vsync = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    chk("d4_second_acks", d4_acks, 8);
    chk("d4_queue_empty", d4_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
